// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks at most one execution pipe per cycle for the single
// register-file write port (starvation > hipri > round-robin) and counts retirements.
module wb_arbiter #(
  parameter int N_SRC        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_SRC-1:0]           src_valid,
  input  logic [N_SRC-1:0]           src_hipri,
  input  logic [N_SRC-1:0]           src_wb_en,
  input  logic [5*N_SRC-1:0]         src_dst,
  input  logic [64*N_SRC-1:0]        src_result,
  input  logic [64*N_SRC-1:0]        src_pc,
  output logic [N_SRC-1:0]           src_ready,
  output logic                       rf_wr_en,
  output logic [4:0]                 rf_wr_dst,
  output logic [63:0]                rf_wr_data,
  output logic                       retire_valid,
  output logic [63:0]                retire_pc,
  output logic [$clog2(N_SRC)-1:0]   retire_src,
  output logic [63:0]                instret
);

  localparam int IDX_W = $clog2(N_SRC);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  // Handshake: a result moves when src_valid[i] && src_ready[i]; src_ready is
  // one-hot or zero and depends only on valid/hipri and internal state.

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] wait_q [N_SRC];
  logic [CNT_W-1:0] wait_d [N_SRC];

  logic [N_SRC-1:0] starve_vec;
  logic [N_SRC-1:0] hipri_vec;
  logic [N_SRC-1:0] gnt_vec;
  logic             gnt_any;
  logic [IDX_W-1:0] gnt_idx;
  logic             rr_found;
  logic [IDX_W-1:0] rr_cand;

  logic             rf_wr_en_q, rf_wr_en_d;
  logic [4:0]       rf_wr_dst_q, rf_wr_dst_d;
  logic [63:0]      rf_wr_data_q, rf_wr_data_d;
  logic             retire_valid_q, retire_valid_d;
  logic [63:0]      retire_pc_q, retire_pc_d;
  logic [IDX_W-1:0] retire_src_q, retire_src_d;
  logic [63:0]      instret_q, instret_d;

  always_comb begin
    starve_vec = '0;
    for (int i = 0; i < N_SRC; i++) begin
      starve_vec[i] = src_valid[i] && (wait_q[i] == LIMIT);
    end
    hipri_vec = src_valid & src_hipri;
  end

  // Descending scans leave the lowest matching index in gnt_idx.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    rr_found = 1'b0;
    rr_cand  = '0;
    if (|starve_vec) begin
      gnt_any = 1'b1;
      for (int i = N_SRC - 1; i >= 0; i--) begin
        if (starve_vec[i]) gnt_idx = IDX_W'(i);
      end
    end else if (|hipri_vec) begin
      gnt_any = 1'b1;
      for (int i = N_SRC - 1; i >= 0; i--) begin
        if (hipri_vec[i]) gnt_idx = IDX_W'(i);
      end
    end else if (|src_valid) begin
      gnt_any = 1'b1;
      for (int k = 0; k < N_SRC; k++) begin
        rr_cand = IDX_W'((int'(rr_ptr_q) + k) % N_SRC);
        if (!rr_found && src_valid[rr_cand]) begin
          rr_found = 1'b1;
          gnt_idx  = rr_cand;
        end
      end
    end
  end

  always_comb begin
    gnt_vec = '0;
    for (int i = 0; i < N_SRC; i++) begin
      gnt_vec[i] = gnt_any && (gnt_idx == IDX_W'(i));
    end
  end

  // A grant in the reset cycle is never acknowledged.
  assign src_ready = rst ? '0 : gnt_vec;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      rr_ptr_d = (gnt_idx == IDX_W'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (!src_valid[i] || gnt_vec[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != LIMIT) begin
        wait_d[i] = wait_q[i] + 1'b1;
      end else begin
        wait_d[i] = wait_q[i];
      end
    end
  end

  always_comb begin
    rf_wr_en_d     = 1'b0;
    retire_valid_d = 1'b0;
    rf_wr_dst_d    = rf_wr_dst_q;
    rf_wr_data_d   = rf_wr_data_q;
    retire_pc_d    = retire_pc_q;
    retire_src_d   = retire_src_q;
    instret_d      = instret_q;
    if (gnt_any) begin
      rf_wr_dst_d    = src_dst[int'(gnt_idx)*5 +: 5];
      rf_wr_en_d     = src_wb_en[gnt_idx] && (src_dst[int'(gnt_idx)*5 +: 5] != 5'd0);
      rf_wr_data_d   = src_result[int'(gnt_idx)*64 +: 64];
      retire_pc_d    = src_pc[int'(gnt_idx)*64 +: 64];
      retire_valid_d = 1'b1;
      retire_src_d   = gnt_idx;
      instret_d      = instret_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q       <= '0;
      rf_wr_en_q     <= 1'b0;
      rf_wr_dst_q    <= '0;
      rf_wr_data_q   <= '0;
      retire_valid_q <= 1'b0;
      retire_pc_q    <= '0;
      retire_src_q   <= '0;
      instret_q      <= '0;
      for (int i = 0; i < N_SRC; i++) wait_q[i] <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      rf_wr_en_q     <= rf_wr_en_d;
      rf_wr_dst_q    <= rf_wr_dst_d;
      rf_wr_data_q   <= rf_wr_data_d;
      retire_valid_q <= retire_valid_d;
      retire_pc_q    <= retire_pc_d;
      retire_src_q   <= retire_src_d;
      instret_q      <= instret_d;
      for (int i = 0; i < N_SRC; i++) wait_q[i] <= wait_d[i];
    end
  end

  assign rf_wr_en     = rf_wr_en_q;
  assign rf_wr_dst    = rf_wr_dst_q;
  assign rf_wr_data   = rf_wr_data_q;
  assign retire_valid = retire_valid_q;
  assign retire_pc    = retire_pc_q;
  assign retire_src   = retire_src_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, round-robin, hipri, starvation,
// x0 suppression, instret rollover and mid-stream reset.
module tb_wb_arbiter;

  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   src_valid;
  logic [N-1:0]   src_hipri;
  logic [N-1:0]   src_wb_en;
  logic [5*N-1:0] src_dst;
  logic [64*N-1:0] src_result;
  logic [64*N-1:0] src_pc;
  logic [N-1:0]   src_ready;
  logic           rf_wr_en;
  logic [4:0]     rf_wr_dst;
  logic [63:0]    rf_wr_data;
  logic           retire_valid;
  logic [63:0]    retire_pc;
  logic [1:0]     retire_src;
  logic [63:0]    instret;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  wb_arbiter #(.N_SRC(N), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_hipri(src_hipri), .src_wb_en(src_wb_en),
    .src_dst(src_dst), .src_result(src_result), .src_pc(src_pc),
    .src_ready(src_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_dst(rf_wr_dst), .rf_wr_data(rf_wr_data),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_src(retire_src),
    .instret(instret)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic drive_idle();
    src_valid  = '0;
    src_hipri  = '0;
    src_wb_en  = '0;
    src_dst    = '0;
    src_result = '0;
    src_pc     = '0;
  endtask

  task automatic set_src(input int i, input logic v, input logic h, input logic we,
                         input logic [4:0] d, input logic [63:0] r, input logic [63:0] pc);
    src_valid[i]          = v;
    src_hipri[i]          = h;
    src_wb_en[i]          = we;
    src_dst[i*5 +: 5]     = d;
    src_result[i*64 +: 64] = r;
    src_pc[i*64 +: 64]     = pc;
  endtask

  // Ends at a negedge with rst just released; the next posedge is the first live cycle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    src_valid = '1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (src_ready !== 4'b0000) begin
        errors++; $display("FAIL reset_ready: got %b expected 0000", src_ready);
      end
      checks++;
      if (rf_wr_en !== 1'b0) begin
        errors++; $display("FAIL reset_wr_en: got %b expected 0", rf_wr_en);
      end
      checks++;
      if (instret !== 64'd0) begin
        errors++; $display("FAIL reset_instret: got %0d expected 0", instret);
      end
      checks++;
      if (retire_valid !== 1'b0) begin
        errors++; $display("FAIL reset_retire_valid: got %b expected 0", retire_valid);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] g;
    logic [1:0] got;
    do_reset();
    for (int i = 0; i < N; i++) set_src(i, 1'b1, 1'b0, 1'b1, 5'd5, 64'h1000 + 64'(i), 64'h8000_0000 + 64'(4*i));
    for (int c = 0; c < 5; c++) begin
      g = 2'(c % 4);
      #1;
      checks++;
      if (src_ready !== (4'b0001 << g)) begin
        errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", c, src_ready, 4'b0001 << g);
      end
      exp_q.push_back(g);
      @(negedge clk);
      #1;
      got = exp_q.pop_front();
      checks++;
      if (rf_wr_en !== 1'b1 || retire_valid !== 1'b1 || rf_wr_dst !== 5'd5) begin
        errors++; $display("FAIL rr_wr[%0d]: got en=%b rv=%b dst=%0d expected 1 1 5", c, rf_wr_en, retire_valid, rf_wr_dst);
      end
      checks++;
      if (retire_src !== got || rf_wr_data !== (64'h1000 + 64'(got)) || retire_pc !== (64'h8000_0000 + 64'(4*got))) begin
        errors++; $display("FAIL rr_fields[%0d]: got src=%0d data=%h pc=%h expected src=%0d", c, retire_src, rf_wr_data, retire_pc, got);
      end
    end
    checks++;
    if (instret !== 64'd5) begin
      errors++; $display("FAIL rr_instret: got %0d expected 5", instret);
    end
    drive_idle();
  endtask

  task automatic test_hipri();
    do_reset();
    for (int i = 0; i < N; i++) set_src(i, 1'b0, 1'b0, 1'b1, 5'(i + 1), 64'(i), 64'(i));
    src_valid = 4'b1011;
    src_hipri = 4'b1010;
    #1;
    checks++;
    if (src_ready !== 4'b0010) begin
      errors++; $display("FAIL hipri_first: got %b expected 0010", src_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (retire_src !== 2'd1 || rf_wr_dst !== 5'd2) begin
      errors++; $display("FAIL hipri_ret1: got src=%0d dst=%0d expected 1 2", retire_src, rf_wr_dst);
    end
    src_valid = 4'b1001;
    src_hipri = 4'b1000;
    #1;
    checks++;
    if (src_ready !== 4'b1000) begin
      errors++; $display("FAIL hipri_second: got %b expected 1000", src_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (retire_src !== 2'd3) begin
      errors++; $display("FAIL hipri_ret3: got %0d expected 3", retire_src);
    end
    src_valid = 4'b0001;
    src_hipri = 4'b0000;
    #1;
    checks++;
    if (src_ready !== 4'b0001) begin
      errors++; $display("FAIL hipri_third: got %b expected 0001", src_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (retire_src !== 2'd0 || retire_valid !== 1'b1) begin
      errors++; $display("FAIL hipri_ret0: got src=%0d rv=%b expected 0 1", retire_src, retire_valid);
    end
    src_valid = '0;
    @(negedge clk);
    #1;
    checks++;
    if (retire_valid !== 1'b0 || rf_wr_en !== 1'b0) begin
      errors++; $display("FAIL hipri_idle: got rv=%b en=%b expected 0 0", retire_valid, rf_wr_en);
    end
    drive_idle();
  endtask

  task automatic test_starvation();
    logic [3:0] exp_rdy;
    do_reset();
    set_src(0, 1'b1, 1'b1, 1'b1, 5'd1, 64'hA0, 64'h0);
    set_src(2, 1'b1, 1'b0, 1'b1, 5'd2, 64'hA2, 64'h8);
    for (int c = 1; c <= 10; c++) begin
      exp_rdy = (c == 9) ? 4'b0100 : 4'b0001;
      #1;
      checks++;
      if (src_ready !== exp_rdy) begin
        errors++; $display("FAIL starve_cycle%0d: got %b expected %b", c, src_ready, exp_rdy);
      end
      @(negedge clk);
      if (c == 9) begin
        #1;
        checks++;
        if (retire_src !== 2'd2 || rf_wr_data !== 64'hA2) begin
          errors++; $display("FAIL starve_retire: got src=%0d data=%h expected 2 a2", retire_src, rf_wr_data);
        end
      end
    end
    drive_idle();
  endtask

  task automatic test_x0_suppress();
    do_reset();
    set_src(0, 1'b1, 1'b0, 1'b1, 5'd0, 64'hDEAD, 64'h40);
    #1;
    checks++;
    if (src_ready !== 4'b0001) begin
      errors++; $display("FAIL x0_ready: got %b expected 0001", src_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rf_wr_en !== 1'b0 || retire_valid !== 1'b1 || instret !== 64'd1) begin
      errors++; $display("FAIL x0_write: got en=%b rv=%b instret=%0d expected 0 1 1", rf_wr_en, retire_valid, instret);
    end
    checks++;
    if (rf_wr_data !== 64'hDEAD || retire_pc !== 64'h40) begin
      errors++; $display("FAIL x0_fields: got data=%h pc=%h expected dead 40", rf_wr_data, retire_pc);
    end
    src_valid = '0;
    @(negedge clk);
    #1;
    checks++;
    if (retire_valid !== 1'b0 || rf_wr_data !== 64'hDEAD || instret !== 64'd1) begin
      errors++; $display("FAIL x0_hold: got rv=%b data=%h instret=%0d expected 0 dead 1", retire_valid, rf_wr_data, instret);
    end
    drive_idle();
  endtask

  task automatic test_rollover_reset();
    do_reset();
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    checks++;
    if (instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL roll_preload: got %h expected ffffffffffffffff", instret);
    end
    set_src(0, 1'b1, 1'b0, 1'b1, 5'd3, 64'h77, 64'h100);
    @(negedge clk);
    #1;
    checks++;
    if (instret !== 64'd0 || retire_valid !== 1'b1) begin
      errors++; $display("FAIL roll_wrap: got instret=%h rv=%b expected 0 1", instret, retire_valid);
    end
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_src(i, 1'b1, 1'b0, 1'b1, 5'(i + 8), 64'(i), 64'(i));
    #1;
    checks++;
    if (src_ready !== 4'b0000) begin
      errors++; $display("FAIL midrst_ready: got %b expected 0000", src_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (retire_valid !== 1'b0 || rf_wr_en !== 1'b0 || instret !== 64'd0 || rf_wr_dst !== 5'd0) begin
      errors++; $display("FAIL midrst_outputs: got rv=%b en=%b instret=%0d dst=%0d expected 0 0 0 0", retire_valid, rf_wr_en, instret, rf_wr_dst);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (src_ready !== 4'b0001) begin
      errors++; $display("FAIL midrst_rrptr: got %b expected 0001", src_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (retire_src !== 2'd0 || instret !== 64'd1 || rf_wr_dst !== 5'd8) begin
      errors++; $display("FAIL midrst_first: got src=%0d instret=%0d dst=%0d expected 0 1 8", retire_src, instret, rf_wr_dst);
    end
    drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_round_robin();
    test_hipri();
    test_starvation();
    test_x0_suppress();
    test_rollover_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the execution pipelines (integer pipes, load/store pipe, mul/div pipe) and the single integer register-file write port. Each cycle it selects at most one requester. The selection order is: starvation override first, then high-priority (branch-carrying) requests, then round-robin. The winner's result is registered onto the write port and a retire strobe. The block also keeps the retired-instruction count used by the CSR unit.

## Interface
Parameters:
- N_SRC, 4, number of requesting pipelines. Minimum 2.
- STARVE_LIMIT, 8, wait cycles after which a requester overrides all other priority. Minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- src_valid  in  N_SRC  per-source result valid
- src_hipri  in  N_SRC  per-source high priority (result carries a resolved branch)
- src_wb_en  in  N_SRC  per-source register write enable
- src_dst  in  5*N_SRC  destination register; source i at [5i+4:5i]
- src_result  in  64*N_SRC  result data; source i at [64i+63:64i]
- src_pc  in  64*N_SRC  instruction PC; source i at [64i+63:64i]
- src_ready  out  N_SRC  per-source accept; one-hot or zero
- rf_wr_en  out  1  register-file write strobe
- rf_wr_dst  out  5  write address
- rf_wr_data  out  64  write data
- retire_valid  out  1  one instruction retired this cycle
- retire_pc  out  64  PC of the retired instruction
- retire_src  out  clog2(N_SRC)  index of the retiring source
- instret  out  64  running count of retired instructions

## Operation
- A source's transfer completes in a cycle where src_valid[i] && src_ready[i]. src_ready depends combinationally on src_valid, src_hipri and internal state. It never depends on src_dst, src_result or src_pc.
- Grant selection, evaluated each cycle over valid sources only:
  1. If any valid source has wait_cnt == STARVE_LIMIT, grant the lowest such index.
  2. Otherwise, if any valid source has src_hipri set, grant the lowest such index.
  3. Otherwise, grant the first valid source found scanning from rr_ptr upward, wrapping N_SRC-1 to 0.
  4. If no source is valid, src_ready = 0.
- src_ready[i] = grant[i]. At most one bit is set.
- rr_ptr: on any grant to index g, rr_ptr <= (g+1) mod N_SRC. Otherwise it holds.
- wait_cnt[i]:
  - If valid and not granted, it increments, saturating at STARVE_LIMIT.
  - On grant or when not valid, it clears to 0.
- On a grant, the following registered outputs update:
  - rf_wr_en <= src_wb_en[g] && (src_dst[g] != 0). Writes to x0 are suppressed.
  - rf_wr_dst, rf_wr_data and retire_pc take source g's fields.
  - retire_valid <= 1, retire_src <= g.
  - instret <= instret + 1, wrapping modulo 2^64.
- On a cycle with no grant: rf_wr_en <= 0 and retire_valid <= 0. Data, dst, pc and src fields hold their previous values.
- Abort is not handled here. Sources mask speculative results from src_valid themselves.

## Timing
- Reset values:
  - rf_wr_en=0, rf_wr_dst=0, rf_wr_data=0
  - retire_valid=0, retire_pc=0, retire_src=0, instret=0
  - rr_ptr=0, all wait_cnt=0
  - src_ready=0 in the reset cycle, regardless of src_valid.
- Latency: a grant in cycle T produces rf_wr_* and retire_* in cycle T+1, valid for exactly one cycle. The write port applies no backpressure.
- Throughput: one retirement per cycle maximum. With k sources continuously valid and no hipri, each source is granted once every k cycles.
- Simultaneous hipri: the lowest index wins. The losers count wait cycles and win in later cycles.
- Starvation: a source continuously denied by hipri traffic reaches STARVE_LIMIT after STARVE_LIMIT denied cycles and is granted on the next cycle, even if higher-priority hipri requests are present.
- A source that drops src_valid while waiting loses its accumulated wait count.
- rst asserted mid-stream: the next cycle shows reset values. Any grant in the rst cycle is discarded; the source is not acknowledged.
- instret rollover: 0xFFFF_FFFF_FFFF_FFFF + 1 -> 0 with no flag.

## Test plan
- Reset check: assert rst for 2 cycles with all src_valid=1. Required: src_ready=0, rf_wr_en=0, instret=0.
- Round-robin: N_SRC=4, all valid, no hipri, all dst=5 with wb_en. Required: grants 0,1,2,3,0 on consecutive cycles; rf_wr_en=1 each cycle from T+1; instret=5 after 5 grants.
- Hipri: src1 and src3 hipri with src0 valid in the same cycle. Required: grant src1; src3 next cycle; then src0.
- Starvation: src2 held valid non-hipri, src0 hipri every cycle, STARVE_LIMIT=8. Required: src0 granted for 8 cycles, src2 granted on cycle 9, then src0 resumes.
- x0 suppression: single source with wb_en=1, dst=0, result 0xDEAD. Required: rf_wr_en=0, retire_valid=1, instret+1.
- Mid-stream reset and rollover: preload instret=0xFFFF_FFFF_FFFF_FFFF and retire once. Required: instret=0. Then assert rst during a grant. Required: next cycle retire_valid=0 and rr_ptr=0.
